// File: rtl/dsram_bridge_pkg.sv
// Shared types and constants for the data-SRAM to request/response bus bridge.
package dsram_bridge_pkg;

  localparam int unsigned STRB_W = 4;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/dsram_bridge_wdog.sv
// Response watchdog: a saturating down-counter that is reloaded by clr, steps down
// while en is high, and flags expired once LIMIT enabled cycles have elapsed since the clear.
module dsram_bridge_wdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  // Loading LIMIT-1 makes the terminal count land on the LIMIT-th enabled cycle.
  localparam logic [CW-1:0] LOAD = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/dsram_req_bridge.sv
// Bridges the core's single-cycle data SRAM port onto a valid/ready request/response bus.
// Define DSRAM_WDOG_EN to enable the response watchdog (TIMEOUT cycles in RSP).
//
// state | meaning
// IDLE  | no access in flight; cpu_en latches the request (stall asserted combinationally)
// REQ   | bus_req_valid high with latched fields, waiting for bus_req_ready
// RSP   | request accepted, waiting for bus_rsp_valid (or watchdog expiry)
// DONE  | stall released, pipeline advances; the still-held cpu_en is ignored
module dsram_req_bridge
  import dsram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic [STRB_W-1:0] cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [STRB_W-1:0] bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_rdata,
  input  logic              bus_rsp_err,
  output logic              err_pulse
);

  bridge_state_e state;
  logic          is_read;
  logic          rsp_timeout;

  assign is_read = (bus_req_we == '0);

`ifdef DSRAM_WDOG_EN
  logic wdog_clr;
  logic wdog_en;
  logic wdog_expired;

  assign wdog_clr = (state == REQ) && bus_req_ready;
  assign wdog_en  = (state == RSP);

  dsram_bridge_wdog #(
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (wdog_expired)
  );

  // A response arriving in the expiry cycle still wins over the timeout.
  assign rsp_timeout = (state == RSP) && !bus_rsp_valid && wdog_expired;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign rsp_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus_req_valid <= 1'b0;
      bus_req_we    <= '0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      cpu_rdata     <= '0;
      err_pulse     <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_en) begin
            bus_req_we    <= cpu_we;
            bus_req_addr  <= cpu_addr;
            bus_req_wdata <= cpu_wdata;
            bus_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state         <= RSP;
          end
        end
        RSP: begin
          if (bus_rsp_valid) begin
            err_pulse <= bus_rsp_err;
            if (is_read) begin
              cpu_rdata <= bus_rsp_err ? ERR_RDATA : bus_rsp_rdata;
            end
            state <= DONE;
          end else if (rsp_timeout) begin
            err_pulse <= 1'b1;
            if (is_read) begin
              cpu_rdata <= ERR_RDATA;
            end
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The IDLE term holds the pipeline in the very cycle the access is presented.
  assign cpu_stall = ((state == IDLE) && cpu_en) || (state == REQ) || (state == RSP);

endmodule

// File: tb/tb_dsram_req_bridge.sv
// Directed testbench for dsram_req_bridge with hand-computed expectations.
module tb_dsram_req_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_en = 1'b0;
  logic [3:0]  cpu_we = '0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic [3:0]  bus_req_we;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rsp_rdata = '0;
  logic        bus_rsp_err = 1'b0;
  logic        err_pulse;

  int n_vec  = 0;
  int n_miss = 0;
  int sc;
  int bad;

  always #5 clk = ~clk;

  dsram_req_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_en        (cpu_en),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_we    (bus_req_we),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_err   (bus_rsp_err),
    .err_pulse     (err_pulse)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one access starting in an IDLE cycle and plays the bus side.
  // Returns in the DONE cycle (stall low) with cpu_en still held.
  task automatic do_access(input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input logic err, input int ready_wait, input int rsp_wait,
                           input logic [31:0] hold_rdata,
                           output int stall_cycles, output int nbad);
    int   phase;
    int   req_cnt;
    int   rsp_cnt;
    logic done;
    phase = 0; req_cnt = 0; rsp_cnt = 0; done = 1'b0;
    stall_cycles = 0; nbad = 0;
    cpu_en = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    for (int c = 0; c < 100; c++) begin
      bus_req_ready = (phase == 1) && (req_cnt == ready_wait);
      bus_rsp_valid = (phase == 2) && (rsp_cnt == rsp_wait);
      bus_rsp_rdata = rdata;
      bus_rsp_err   = bus_rsp_valid && err;
      #1;
      if (cpu_stall !== 1'b1) begin
        done = 1'b1;
        break;
      end
      stall_cycles++;
      if (cpu_rdata !== hold_rdata) nbad++;
      if (phase == 1) begin
        if (bus_req_valid !== 1'b1 || bus_req_we !== we ||
            bus_req_addr !== addr || bus_req_wdata !== wdata) nbad++;
      end else if (bus_req_valid !== 1'b0) begin
        nbad++;
      end
      @(posedge clk);
      #1;
      case (phase)
        0: phase = 1;
        1: if (bus_req_ready) phase = 2; else req_cnt++;
        2: if (bus_rsp_valid) phase = 3; else rsp_cnt++;
        default: phase = 3;
      endcase
    end
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    #1;
    check_vec("txn_done", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #2;
    check_vec("rst_stall", {31'b0, cpu_stall}, 32'd0);
    check_vec("rst_valid", {31'b0, bus_req_valid}, 32'd0);
    check_vec("rst_rdata", cpu_rdata, 32'h0);
    check_vec("rst_err",   {31'b0, err_pulse}, 32'd0);
    check_vec("rst_addr",  bus_req_addr, 32'h0);
    #15 reset = 1'b0;
    next_cycle();

    // Read, zero wait
    do_access(4'b0000, 32'h1C00_0100, 32'h0, 32'h1234_5678, 1'b0, 0, 0, 32'h0, sc, bad);
    check_vec("rd0_stall_cycles", sc, 32'd3);
    check_vec("rd0_bus", bad, 32'd0);
    check_vec("rd0_rdata_done", cpu_rdata, 32'h1234_5678);
    check_vec("rd0_err_done", {31'b0, err_pulse}, 32'd0);
    check_vec("rd0_addr", bus_req_addr, 32'h1C00_0100);
    next_cycle();
    cpu_en = 1'b0;
    #1;
    check_vec("rd0_rdata_after", cpu_rdata, 32'h1234_5678);
    check_vec("rd0_done_ignores_en", {31'b0, bus_req_valid}, 32'd0);
    check_vec("rd0_stall_after", {31'b0, cpu_stall}, 32'd0);
    next_cycle();

    // Write with 4 cycles of backpressure
    do_access(4'b0011, 32'h1C00_0104, 32'h0000_BEEF, 32'hAAAA_5555, 1'b0, 4, 0,
              32'h1234_5678, sc, bad);
    check_vec("wr_stall_cycles", sc, 32'd7);
    check_vec("wr_bus_stable", bad, 32'd0);
    check_vec("wr_rdata_kept", cpu_rdata, 32'h1234_5678);
    check_vec("wr_we", {28'b0, bus_req_we}, 32'h3);
    check_vec("wr_wdata", bus_req_wdata, 32'h0000_BEEF);
    check_vec("wr_err", {31'b0, err_pulse}, 32'd0);
    next_cycle();
    cpu_en = 1'b0;
    next_cycle();

    // Read with error response
    do_access(4'b0000, 32'h1C00_0200, 32'h0, 32'hCAFE_F00D, 1'b1, 1, 2,
              32'h1234_5678, sc, bad);
    check_vec("er_stall_cycles", sc, 32'd6);
    check_vec("er_bus", bad, 32'd0);
    check_vec("er_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check_vec("er_pulse_on", {31'b0, err_pulse}, 32'd1);
    next_cycle();
    cpu_en = 1'b0;
    #1;
    check_vec("er_pulse_off", {31'b0, err_pulse}, 32'd0);
    check_vec("er_rdata_after", cpu_rdata, 32'hDEAD_BEEF);
    next_cycle();

    // Back-to-back reads
    do_access(4'b0000, 32'h1C00_0300, 32'h0, 32'h1111_1111, 1'b0, 0, 0,
              32'hDEAD_BEEF, sc, bad);
    check_vec("b2b_a_stall_cycles", sc, 32'd3);
    check_vec("b2b_a_rdata", cpu_rdata, 32'h1111_1111);
    next_cycle();
    do_access(4'b0000, 32'h1C00_0304, 32'h0, 32'h2222_2222, 1'b0, 2, 1,
              32'h1111_1111, sc, bad);
    check_vec("b2b_b_stall_cycles", sc, 32'd6);
    check_vec("b2b_b_hold_and_bus", bad, 32'd0);
    check_vec("b2b_b_rdata", cpu_rdata, 32'h2222_2222);
    check_vec("b2b_b_addr", bus_req_addr, 32'h1C00_0304);
    next_cycle();
    cpu_en = 1'b0;
    next_cycle();

    // Reset while waiting in RSP, then a stray response
    cpu_en = 1'b1; cpu_we = 4'b0000; cpu_addr = 32'h1C00_0400;
    next_cycle();
    bus_req_ready = 1'b1;
    next_cycle();
    bus_req_ready = 1'b0;
    next_cycle();
    check_vec("rs_pre_stall", {31'b0, cpu_stall}, 32'd1);
    reset = 1'b1;
    cpu_en = 1'b0;
    #1;
    check_vec("rs_valid", {31'b0, bus_req_valid}, 32'd0);
    check_vec("rs_stall", {31'b0, cpu_stall}, 32'd0);
    check_vec("rs_rdata", cpu_rdata, 32'h0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h9999_9999; bus_rsp_err = 1'b1;
    next_cycle();
    bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
    #1;
    check_vec("rs_stray_rdata", cpu_rdata, 32'h0);
    check_vec("rs_stray_err", {31'b0, err_pulse}, 32'd0);
    check_vec("rs_stray_stall", {31'b0, cpu_stall}, 32'd0);
    check_vec("rs_stray_valid", {31'b0, bus_req_valid}, 32'd0);
    next_cycle();

`ifdef DSRAM_WDOG_EN
    // No response: watchdog ends the access after 8 RSP cycles
    do_access(4'b0000, 32'h1C00_0500, 32'h0, 32'h0000_0005, 1'b0, 0, 1000,
              32'h0, sc, bad);
    check_vec("wd_stall_cycles", sc, 32'd10);
    check_vec("wd_bus", bad, 32'd0);
    check_vec("wd_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check_vec("wd_err", {31'b0, err_pulse}, 32'd1);
    next_cycle();
    cpu_en = 1'b0;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h0000_0055;
    #1;
    check_vec("wd_err_off", {31'b0, err_pulse}, 32'd0);
    next_cycle();
    bus_rsp_valid = 1'b0;
    #1;
    check_vec("wd_late_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check_vec("wd_late_err", {31'b0, err_pulse}, 32'd0);
    check_vec("wd_late_stall", {31'b0, cpu_stall}, 32'd0);
    next_cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
